// File: rtl/jstk2_spi_responder_pkg.sv
// jstk2_pkg: shared constants for the JSTK2 joystick SPI responder.
//   - FSM state encoding
//   - default report length and byte-index constants
//   - report_byte(): maps a byte index to its report byte
package jstk2_pkg;

  localparam logic [1:0] S_WAIT_CS_HIGH = 2'd0;
  localparam logic [1:0] S_IDLE         = 2'd1;
  localparam logic [1:0] S_ACTIVE       = 2'd2;

  localparam int FRAME_BYTES = 5;

  localparam logic [2:0] IDX_XL  = 3'd0;
  localparam logic [2:0] IDX_XH  = 3'd1;
  localparam logic [2:0] IDX_YL  = 3'd2;
  localparam logic [2:0] IDX_YH  = 3'd3;
  localparam logic [2:0] IDX_BTN = 3'd4;

  // Any index past the button byte reads as zero.
  function automatic logic [7:0] report_byte(input logic [2:0] idx,
                                             input logic [9:0] x,
                                             input logic [9:0] y,
                                             input logic [7:0] btn);
    case (idx)
      IDX_XL:  return x[7:0];
      IDX_XH:  return {6'b0, x[9:8]};
      IDX_YL:  return y[7:0];
      IDX_YH:  return {6'b0, y[9:8]};
      IDX_BTN: return btn;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/jstk2_spi_responder_if.sv
// jstk2_spi_responder_if: the four-wire SPI link between the joystick
// reader (master) and the responder (slave).
//   CS_n  chip select, active-low (master -> slave)
//   SCK   serial clock, idles low (master -> slave)
//   MOSI  master data (master -> slave)
//   MISO  responder data, MSB first (slave -> master)
interface jstk2_spi_responder_if;
  logic CS_n;
  logic SCK;
  logic MOSI;
  logic MISO;

  modport master (output CS_n, output SCK, output MOSI, input MISO);
  modport slave  (input CS_n, input SCK, input MOSI, output MISO);
endinterface

// File: rtl/jstk2_spi_responder_sync.sv
// spi_in_sync: STAGES-deep flop synchronizer for one asynchronous SPI pin,
// with rise/fall detection on the synchronized copy.
//   CLK, RST  system clock, async active-high reset
//   d         raw asynchronous input
//   q         synchronized level
//   rise/fall single-cycle edge strobes, combinational from q
module spi_in_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_sr;
  logic              q_prev;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_sr <= '0;
      q_prev  <= 1'b0;
    end else begin
      sync_sr <= {sync_sr[STAGES-2:0], d};
      q_prev  <= sync_sr[STAGES-1];
    end
  end

  assign q    = sync_sr[STAGES-1];
  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: rtl/jstk2_spi_responder.sv
// jstk2_spi_responder: SPI mode 0 peripheral emulating the JSTK2 joystick.
// Each chip-select frame returns X lo, X hi, Y lo, Y hi, buttons (snapshot
// taken at CS_n fall), then zeros; MOSI bytes are reported on rx_*.
//   CLK, RST        system clock, async active-high reset
//   spi             SPI link (slave modport)
//   x_pos, y_pos    10-bit joystick position to report
//   buttons         button byte to report
//   rx_byte/rx_dv   last complete MOSI byte and its one-cycle strobe
//   rx_index        byte position in frame, reads 7 past FRAME_BYTES
//   frame_done/err  one-cycle strobe at CS_n rise: well-formed / malformed
module jstk2_spi_responder
  import jstk2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BYTES = jstk2_pkg::FRAME_BYTES
) (
  input  logic                    CLK,
  input  logic                    RST,
  jstk2_spi_responder_if.slave    spi,
  input  logic [9:0]              x_pos,
  input  logic [9:0]              y_pos,
  input  logic [7:0]              buttons,
  output logic [7:0]              rx_byte,
  output logic                    rx_dv,
  output logic [2:0]              rx_index,
  output logic                    frame_done,
  output logic                    frame_err
);

  localparam logic [3:0] FB = 4'(FRAME_BYTES);

  logic cs_q, cs_rise, cs_fall;
  logic sck_q_unused, sck_rise, sck_fall;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .CLK(CLK), .RST(RST), .d(spi.CS_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .CLK(CLK), .RST(RST), .d(spi.SCK), .q(sck_q_unused), .rise(sck_rise), .fall(sck_fall)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .CLK(CLK), .RST(RST), .d(spi.MOSI), .q(mosi_q),
    .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic [1:0] state;
  logic [9:0] snap_x, snap_y;
  logic [7:0] snap_btn;
  logic [7:0] tx_sr;     // MISO is always tx_sr[7]
  logic [6:0] rx_sr;     // the 8th bit comes straight from mosi_q
  logic [2:0] bit_cnt;
  logic [2:0] byte_cnt;
  logic [7:0] next_tx;
  logic [7:0] rx_full;

  // byte_cnt already points at the next byte when the 8th SCK fall arrives.
  assign next_tx = ({1'b0, byte_cnt} < FB) ?
                   report_byte(byte_cnt, snap_x, snap_y, snap_btn) : 8'h00;
  assign rx_full = {rx_sr, mosi_q};
  assign spi.MISO = tx_sr[7];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_WAIT_CS_HIGH;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_btn   <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rx_byte    <= '0;
      rx_dv      <= 1'b0;
      rx_index   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_dv      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_WAIT_CS_HIGH: begin
          tx_sr <= '0;
          if (cs_q) state <= S_IDLE;
        end
        S_IDLE: begin
          tx_sr <= '0;
          if (cs_fall) begin
            snap_x   <= x_pos;
            snap_y   <= y_pos;
            snap_btn <= buttons;
            tx_sr    <= report_byte(IDX_XL, x_pos, y_pos, buttons);
            rx_sr    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            state    <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          // CS_n rise wins over any SCK edge in the same cycle.
          if (cs_rise) begin
            state <= S_IDLE;
            tx_sr <= '0;
            if (({1'b0, byte_cnt} >= FB) && (bit_cnt == 3'd0))
              frame_done <= 1'b1;
            else
              frame_err <= 1'b1;
          end else if (sck_rise) begin
            rx_sr   <= rx_full[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_byte  <= rx_full;
              rx_dv    <= 1'b1;
              // Only the first surplus byte keeps its true index; later
              // overflow bytes all read as 7.
              rx_index <= ({1'b0, byte_cnt} > FB) ? 3'd7 : byte_cnt;
              if (byte_cnt != 3'd7) byte_cnt <= byte_cnt + 3'd1;
            end
          end else if (sck_fall) begin
            if (bit_cnt == 3'd0)
              tx_sr <= next_tx;
            else
              tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end
        default: begin
          state <= S_WAIT_CS_HIGH;
          tx_sr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jstk2_spi_responder.sv
module tb_jstk2_spi_responder;

  localparam int HALF = 12;

  logic       CLK;
  logic       RST;
  logic [9:0] x_pos, y_pos;
  logic [7:0] buttons;
  logic [7:0] rx_byte;
  logic       rx_dv;
  logic [2:0] rx_index;
  logic       frame_done, frame_err;

  jstk2_spi_responder_if spi_if ();

  jstk2_spi_responder dut (
    .CLK(CLK), .RST(RST), .spi(spi_if.slave),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
    .rx_byte(rx_byte), .rx_dv(rx_dv), .rx_index(rx_index),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  exp_miso_q [$];
  logic [10:0] exp_rx_q   [$];   // {index, byte}
  logic        exp_frm_q  [$];   // 0 = frame_done, 1 = frame_err
  logic [7:0]  mosi_buf   [0:7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [7:0] model_byte(input int i);
    case (i)
      0: return x_pos[7:0];
      1: return {6'b0, x_pos[9:8]};
      2: return y_pos[7:0];
      3: return {6'b0, y_pos[9:8]};
      4: return buttons;
      default: return 8'h00;
    endcase
  endfunction

  task automatic sck_bit(input logic mosi_b, output logic miso_b);
    spi_if.MOSI = mosi_b;
    wait_clk(HALF);
    miso_b = spi_if.MISO;
    spi_if.SCK = 1'b1;
    wait_clk(HALF);
    spi_if.SCK = 1'b0;
  endtask

  task automatic run_frame(input int nbytes, input int xbits,
                           input logic chg_x, input logic [9:0] new_x);
    logic [7:0] got;
    logic       b;
    logic [7:0] e;
    for (int i = 0; i < nbytes; i++) begin
      exp_miso_q.push_back(model_byte(i));
      exp_rx_q.push_back({(i > 5) ? 3'd7 : 3'(i), mosi_buf[i]});
    end
    exp_frm_q.push_back(!(nbytes >= 5 && xbits == 0));
    spi_if.CS_n = 1'b0;
    wait_clk(20);
    if (chg_x) x_pos = new_x;
    for (int i = 0; i < nbytes; i++) begin
      for (int k = 7; k >= 0; k--) begin
        sck_bit(mosi_buf[i][k], b);
        got[k] = b;
      end
      e = exp_miso_q.pop_front();
      chk("miso_byte", got, e);
    end
    for (int k = 0; k < xbits; k++) sck_bit(1'b1, b);
    wait_clk(HALF);
    spi_if.CS_n = 1'b1;
    wait_clk(20);
  endtask

  always @(negedge CLK) begin
    logic [10:0] er;
    logic        ef;
    if (rx_dv) begin
      if (exp_rx_q.size() == 0) chk("rx_unexpected", 1, 0);
      else begin
        er = exp_rx_q.pop_front();
        chk("rx_byte", rx_byte, er[7:0]);
        chk("rx_index", rx_index, er[10:8]);
      end
    end
    if (frame_done || frame_err) begin
      if (exp_frm_q.size() == 0) chk("frame_unexpected", 1, 0);
      else begin
        ef = exp_frm_q.pop_front();
        chk("frame_done", frame_done, !ef);
        chk("frame_err", frame_err, ef);
      end
    end
  end

  initial begin
    logic b;
    RST = 1'b1;
    spi_if.CS_n = 1'b1;
    spi_if.SCK  = 1'b0;
    spi_if.MOSI = 1'b0;
    x_pos = 10'h2A5;
    y_pos = 10'h1C3;
    buttons = 8'h05;
    wait_clk(5);
    chk("rst_miso", spi_if.MISO, 0);
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_rx_dv", rx_dv, 0);
    chk("rst_rx_index", rx_index, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_err", frame_err, 0);
    RST = 1'b0;
    wait_clk(20);

    // All-zero commands, report A5 02 C3 01 05
    for (int i = 0; i < 8; i++) mosi_buf[i] = 8'h00;
    run_frame(5, 0, 1'b0, 10'h0);

    // Command bytes echoed with their indices
    mosi_buf[0] = 8'h84; mosi_buf[1] = 8'h11; mosi_buf[2] = 8'h22;
    mosi_buf[3] = 8'h33; mosi_buf[4] = 8'h44; mosi_buf[5] = 8'h55;
    mosi_buf[6] = 8'h66; mosi_buf[7] = 8'h77;
    run_frame(5, 0, 1'b0, 10'h0);

    // x changes after CS_n fall: frame keeps snapshot, next frame sees it
    run_frame(5, 0, 1'b1, 10'h3FF);
    run_frame(5, 0, 1'b0, 10'h0);
    x_pos = 10'h2A5;

    // Truncated frame, then a clean one
    run_frame(3, 4, 1'b0, 10'h0);
    run_frame(5, 0, 1'b0, 10'h0);

    // Over-long frame
    buttons = 8'hC3;
    run_frame(7, 0, 1'b0, 10'h0);

    // Reset mid-byte with CS_n low: no response until CS_n cycles
    spi_if.CS_n = 1'b0;
    wait_clk(20);
    for (int k = 0; k < 4; k++) sck_bit(1'b1, b);
    RST = 1'b1;
    wait_clk(2);
    chk("midrst_miso", spi_if.MISO, 0);
    RST = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sck_bit(1'b1, b);
      chk("midrst_miso_hold", b, 0);
    end
    wait_clk(HALF);
    spi_if.CS_n = 1'b1;
    wait_clk(20);
    y_pos = 10'h3E7;
    run_frame(5, 0, 1'b0, 10'h0);

    wait_clk(30);
    chk("rx_q_drained", exp_rx_q.size(), 0);
    chk("frm_q_drained", exp_frm_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
